toggle_handshake_receiver: RTL and testbench
============================================

Name: toggle_handshake_receiver

Overview:
- Receive end of a toggle-based request/acknowledge handshake that crosses clock domains.
- The sender flips Req_Toggle_In once per transfer, typically from a T flip-flop, and holds Data_In stable until it sees Ack_Toggle_Out flip.
- The block synchronises the toggle, converts each toggle into a captured word with a Valid/Ready output handshake, then flips Ack_Toggle_Out to return acknowledgement to the sender.

Parameters:
- DATA_WIDTH, 8, width of Data_In/Data_Out.
- SYNC_STAGES, 2, synchroniser depth on Req_Toggle_In; legal values >= 2.
- CNT_WIDTH, 8, width of Event_Count_Out; used only with the optional feature.

Ports:
- Clk_In  input  1  receiver clock; all flops update on the falling edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Req_Toggle_In  input  1  request toggle from sender domain, asynchronous to Clk_In.
- Data_In  input  DATA_WIDTH  sender data; stable from Req toggle until Ack toggle.
- Ready_In  input  1  downstream accepts Data_Out while Valid_Out=1.
- Valid_Out  output  1  Data_Out holds an unconsumed word.
- Data_Out  output  DATA_WIDTH  captured word.
- Ack_Toggle_Out  output  1  flips once per completed transfer.
- Busy_Out  output  1  high whenever FSM is not IDLE.
- Overrun_Out  output  1  sticky protocol-violation flag.
- Event_Count_Out  output  CNT_WIDTH  completed-transfer count; present only with EVENT_COUNTER_EN.

Behaviour:
- Reset (async, immediate, regardless of clock):
  - synchroniser chain, req_last, Valid_Out, Data_Out, Ack_Toggle_Out, Busy_Out, Overrun_Out, Event_Count_Out all go to 0.
  - FSM goes to IDLE.
  - The sender must be reset in the same event so both toggles restart at 0.
- Synchroniser: SYNC_STAGES flops in series; sync_q is the last stage. Event condition: sync_q != req_last.
- FSM states: IDLE, CAPTURE, PRESENT, ACK.
  - IDLE: if event, req_last <= sync_q and go to CAPTURE; otherwise stay.
  - CAPTURE: Data_Out <= Data_In, Valid_Out <= 1, go to PRESENT.
  - PRESENT: Valid_Out=1 and Data_Out held. Transfer occurs on an edge with Ready_In=1; then Valid_Out <= 0 and go to ACK. Ready_In=0 holds indefinitely.
  - ACK: Ack_Toggle_Out <= ~Ack_Toggle_Out, go to IDLE.
- Latency:
  - Call the edge where the event is first seen in IDLE edge 0.
  - Valid_Out rises after edge 1.
  - Minimum Ready-to-Ack is 2 edges: transfer edge, then the ACK edge flips Ack_Toggle_Out.
  - Async input to Valid_Out: SYNC_STAGES+2 edges, +1 for metastability uncertainty.
- Busy_Out is registered and equals (next state != IDLE).
- Back-to-back transfers: a new event seen in IDLE immediately after ACK is accepted with no bubble beyond the IDLE cycle.
- Overrun:
  - If sync_q != req_last in CAPTURE, PRESENT or ACK, the sender toggled before the acknowledge. Set Overrun_Out=1 and hold it until reset.
  - A pending event still present on return to IDLE is serviced normally.
  - A double toggle that restores equality is lost and is not recovered.
- Data_In is sampled only in CAPTURE; changes at any other time are ignored.
- Ready_In is ignored when Valid_Out=0.

Optional Feature:
- Macro name: EVENT_COUNTER_EN.
- Defined:
  - Event_Count_Out increments by 1 on every ACK state edge.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no flag.
  - Reset value is 0.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert Reset_In mid-clock, with no clock edge. All outputs read 0 immediately and the FSM is IDLE.
- Single transfer: Data_In=8'hA5, toggle Req 0->1, Ready_In held 1.
  - Valid_Out pulses for 1 cycle with Data_Out=8'hA5.
  - Ack_Toggle_Out goes 0->1 one edge later.
  - Busy_Out falls afterwards; Overrun_Out stays 0.
- Backpressure: Data_In=8'h3C, Ready_In=0 for 10 cycles, then 1.
  - Valid_Out stays high for all 10 cycles with Data_Out=8'h3C.
  - Ack flips only after Ready_In rises.
  - Changing Data_In to 8'hFF during the wait does not alter Data_Out.
- Streaming: 4 transfers 8'h01..8'h04, with the sender toggling Req on each Ack flip.
  - Four Valid pulses appear in order.
  - Ack toggles 0,1,0,1,0.
  - Event_Count_Out=4 when EVENT_COUNTER_EN is defined.
- Overrun: toggle Req twice while in PRESENT with Ready_In=0. Overrun_Out rises and stays 1 after the transfer completes; only Reset_In clears it.
- Reset mid-operation: assert Reset_In while in PRESENT with Valid_Out=1. Valid_Out=0, Ack_Toggle_Out=0 and the FSM is IDLE at once; the next fresh toggle is received normally.

Source files
------------

// File: rtl/toggle_handshake_receiver.sv
// Receive side of a toggle request/acknowledge crossing: synchronises the request toggle,
// presents each word with Valid/Ready and flips the ack toggle. Optional: EVENT_COUNTER_EN.
module toggle_handshake_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
`ifdef EVENT_COUNTER_EN
  ,
  parameter int CNT_WIDTH   = 8
`endif
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Req_Toggle_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Ready_In,
  output logic                  Valid_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Ack_Toggle_Out,
  output logic                  Busy_Out,
  output logic                  Overrun_Out,
`ifdef EVENT_COUNTER_EN
  output logic [CNT_WIDTH-1:0]  Event_Count_Out,
`endif
  output logic [1:0]            State_Out
);

  // Output handshake: a word moves on a falling edge where Valid_Out=1 and Ready_In=1;
  // Valid_Out never drops without that edge, and Ready_In is ignored while Valid_Out=0.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PRESENT = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_chain_q, sync_chain_d;
  logic                    req_last_q, req_last_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    sync_q;
  logic                    req_event;
`ifdef EVENT_COUNTER_EN
  logic [CNT_WIDTH-1:0]    count_q, count_d;
`endif

  assign sync_q    = sync_chain_q[SYNC_STAGES-1];
  assign req_event = (sync_q != req_last_q);

  always_comb begin
    sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], Req_Toggle_In};
    state_d      = state_q;
    req_last_d   = req_last_q;
    valid_d      = valid_q;
    data_d       = data_q;
    ack_d        = ack_q;
    // A toggle arriving before we have acknowledged the previous one is a sender error.
    overrun_d    = overrun_q | (req_event && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (req_event) begin
          req_last_d = sync_q;
          state_d    = CAPTURE;
        end
      end
      CAPTURE: begin
        data_d  = Data_In;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (Ready_In) begin
          valid_d = 1'b0;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d   = ~ack_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

`ifdef EVENT_COUNTER_EN
  always_comb begin
    count_d = count_q;
    if (state_q == ACK) count_d = count_q + 1'b1;
  end
`endif

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q      <= IDLE;
      sync_chain_q <= '0;
      req_last_q   <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef EVENT_COUNTER_EN
      count_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync_chain_q <= sync_chain_d;
      req_last_q   <= req_last_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
`ifdef EVENT_COUNTER_EN
      count_q      <= count_d;
`endif
    end
  end

  assign Valid_Out      = valid_q;
  assign Data_Out       = data_q;
  assign Ack_Toggle_Out = ack_q;
  assign Busy_Out       = busy_q;
  assign Overrun_Out    = overrun_q;
  assign State_Out      = state_q;
`ifdef EVENT_COUNTER_EN
  assign Event_Count_Out = count_q;
`endif

endmodule

// File: tb/tb_toggle_handshake_receiver.sv
// Directed bench for toggle_handshake_receiver: reset, single, backpressure, streaming,
// overrun and mid-operation reset scenarios with hand-computed expectations.
module tb_toggle_handshake_receiver;

  localparam int DW = 8;
  localparam int SYNC = 2;
  localparam int LAT = SYNC + 2;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic          clk;
  logic          rst;
  logic          req;
  logic [DW-1:0] din;
  logic          rdy;
  logic          valid;
  logic [DW-1:0] dout;
  logic          ack;
  logic          busy;
  logic          ovr;
  logic [1:0]    st;
`ifdef EVENT_COUNTER_EN
  logic [7:0]    cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic exp_ack;

  toggle_handshake_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .Clk_In(clk),
    .Reset_In(rst),
    .Req_Toggle_In(req),
    .Data_In(din),
    .Ready_In(rdy),
    .Valid_Out(valid),
    .Data_Out(dout),
    .Ack_Toggle_Out(ack),
    .Busy_Out(busy),
    .Overrun_Out(ovr),
`ifdef EVENT_COUNTER_EN
    .Event_Count_Out(cnt),
`endif
    .State_Out(st)
  );

  // Clock: DUT acts on falling edges; bench drives and samples on rising edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waits until Valid_Out is seen high; cycles = -1 on timeout.
  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(posedge clk);
      if (valid === 1'b1) begin
        cycles = i;
        return;
      end
    end
  endtask

  // Waits until Ack_Toggle_Out differs from prev; cycles = -1 on timeout.
  task automatic wait_ack(input logic prev, input int max_cycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(posedge clk);
      if (ack !== prev) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    exp_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", dout); end
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", ovr); end
    checks++;
    if (st !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", st); end
`ifdef EVENT_COUNTER_EN
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt); end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ack = 1'b0;
  endtask

  task automatic test_single();
    int c;
    @(posedge clk);
    din = 8'hA5;
    rdy = 1'b1;
    req = ~req;
    wait_valid(20, c);
    checks++;
    if (c !== LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", c, LAT); end
    checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", dout); end
    @(posedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse got %b want 0", valid); end
    checks++;
    if (ack !== exp_ack) begin errors++; $display("FAIL single_ack_early got %b want %b", ack, exp_ack); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_in_ack got %b want 1", busy); end
    @(posedge clk);
    exp_ack = ~exp_ack;
    checks++;
    if (ack !== exp_ack) begin errors++; $display("FAIL single_ack got %b want %b", ack, exp_ack); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL single_overrun got %b want 0", ovr); end
  endtask

  task automatic test_backpressure();
    int c;
    int bad_v;
    int bad_d;
    int bad_a;
    @(posedge clk);
    din = 8'h3C;
    rdy = 1'b0;
    req = ~req;
    wait_valid(20, c);
    checks++;
    if (c !== LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", c, LAT); end
    bad_v = 0;
    bad_d = 0;
    bad_a = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) din = 8'hFF;
      @(posedge clk);
      if (valid !== 1'b1) bad_v++;
      if (dout !== 8'h3C) bad_d++;
      if (ack !== exp_ack) bad_a++;
    end
    checks++;
    if (bad_v != 0) begin errors++; $display("FAIL bp_valid_held dropped %0d cycles want 0", bad_v); end
    checks++;
    if (bad_d != 0) begin errors++; $display("FAIL bp_data_held wrong %0d cycles want 0 (last %h)", bad_d, dout); end
    checks++;
    if (bad_a != 0) begin errors++; $display("FAIL bp_ack_early flipped %0d cycles want 0", bad_a); end
    rdy = 1'b1;
    wait_ack(exp_ack, 10, c);
    exp_ack = ~exp_ack;
    checks++;
    if (c !== 2) begin errors++; $display("FAIL bp_ready_to_ack got %0d want 2", c); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b want 0", valid); end
  endtask

  task automatic test_streaming();
    int c;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;
    pulse_reset();
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(k + 1));
    @(posedge clk);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL stream_ack_start got %b want 0", ack); end
    for (int k = 0; k < 4; k++) begin
      exp_w = exp_q.pop_front();
      din = exp_w;
      req = ~req;
      wait_valid(20, c);
      checks++;
      if (c !== LAT) begin errors++; $display("FAIL stream_latency[%0d] got %0d want %0d", k, c, LAT); end
      checks++;
      if (dout !== exp_w) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", k, dout, exp_w); end
      wait_ack(exp_ack, 10, c);
      exp_ack = ~exp_ack;
      checks++;
      if (ack !== exp_ack) begin errors++; $display("FAIL stream_ack[%0d] got %b want %b", k, ack, exp_ack); end
    end
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL stream_overrun got %b want 0", ovr); end
`ifdef EVENT_COUNTER_EN
    checks++;
    if (cnt !== 8'd4) begin errors++; $display("FAIL stream_count got %0d want 4", cnt); end
`endif
  endtask

  task automatic test_overrun();
    int c;
    @(posedge clk);
    din = 8'h77;
    rdy = 1'b0;
    req = ~req;
    wait_valid(20, c);
    checks++;
    if (c !== LAT) begin errors++; $display("FAIL ovr_latency got %0d want %0d", c, LAT); end
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_before got %b want 0", ovr); end
    req = ~req;
    repeat (5) @(posedge clk);
    checks++;
    if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", ovr); end
    req = ~req;
    repeat (5) @(posedge clk);
    rdy = 1'b1;
    wait_ack(exp_ack, 10, c);
    exp_ack = ~exp_ack;
    checks++;
    if (c !== 2) begin errors++; $display("FAIL ovr_ack got %0d cycles want 2", c); end
    repeat (6) @(posedge clk);
    checks++;
    if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", ovr); end
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL ovr_lost_toggle busy %b valid %b want 0 0", busy, valid);
    end
    pulse_reset();
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b want 0", ovr); end
  endtask

  task automatic test_reset_mid_op();
    int c;
    @(posedge clk);
    din = 8'hC3;
    rdy = 1'b0;
    req = ~req;
    wait_valid(20, c);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before got %b want 1", valid); end
    #1;
    rst = 1'b1;
    req = 1'b0;
    exp_ack = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid); end
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL mid_ack got %b want 0", ack); end
    checks++;
    if (st !== ST_IDLE) begin errors++; $display("FAIL mid_state got %0d want 0", st); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    din = 8'h5A;
    rdy = 1'b1;
    req = ~req;
    wait_valid(20, c);
    checks++;
    if (c !== LAT) begin errors++; $display("FAIL mid_next_latency got %0d want %0d", c, LAT); end
    checks++;
    if (dout !== 8'h5A) begin errors++; $display("FAIL mid_next_data got %h want 5a", dout); end
    wait_ack(exp_ack, 10, c);
    exp_ack = ~exp_ack;
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL mid_next_ack got %b want 1", ack); end
  endtask

  initial begin
    rst = 1'b0;
    req = 1'b0;
    din = '0;
    rdy = 1'b0;
    exp_ack = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_overrun();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
